gray_read_arbiter: RTL and testbench

Two-master arbiter that shares the single gray-image memory read port between the LBP engine (master 0) and a second image-processing engine (master 1). It sits between the engines and the gray memory. It grants whole bursts in round-robin order, forwards addresses and the request, and routes each returned pixel to the master that issued it, so neither engine needs to know the port is shared.

---
 rtl/gray_read_arbiter.sv | 136 +++++++++++++
 tb/tb_gray_read_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gray_read_arbiter.sv
// rtl/gray_read_arbiter.sv - two-master round-robin burst arbiter for the gray-image read port
// Optional burst limit: define GRAY_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST beats
// whenever the other master is waiting.
module gray_read_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_last,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_last,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_ready,
  input  logic [DATA_W-1:0] gray_data,
  output logic              busy
);

`ifdef GRAY_ARB_BURST_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                rv0_q, rv0_d;
  logic                rv1_q, rv1_d;

  logic                sel1;
  logic                own_req;
  logic                own_last;
  logic [ADDR_W-1:0]   own_addr;
  logic                other_req;
  logic                accept;
  logic                limit_hit;
  logic                release_grant;
  logic [7:0]          cnt_inc;

  // Next-state, grant and memory-request decode; the granted master owns the port outright.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    cnt_d         = cnt_q;
    m0_gnt        = 1'b0;
    m1_gnt        = 1'b0;
    gray_req      = 1'b0;
    gray_addr     = addr_q;
    rv0_d         = 1'b0;
    rv1_d         = 1'b0;
    sel1          = (state_q == GNT1);
    own_req       = sel1 ? m1_req  : m0_req;
    own_last      = sel1 ? m1_last : m0_last;
    own_addr      = sel1 ? m1_addr : m0_addr;
    other_req     = sel1 ? m0_req  : m1_req;
    accept        = 1'b0;
    limit_hit     = 1'b0;
    release_grant = 1'b0;
    cnt_inc       = cnt_q + 8'd1;

    if (state_q == IDLE) begin
      cnt_d = 8'd0;
      if (m0_req && (!m1_req || !prio_q)) begin
        state_d = GNT0;
      end else if (m1_req) begin
        state_d = GNT1;
      end
    end else begin
      gray_req  = own_req;
      gray_addr = own_addr;
      accept    = own_req & gray_ready;
      m0_gnt    = accept & ~sel1;
      m1_gnt    = accept &  sel1;
      rv0_d     = m0_gnt;
      rv1_d     = m1_gnt;
      if (accept) begin
        cnt_d = cnt_inc;
      end
      // Reaching the cap only hands over when someone is waiting; otherwise restart the count.
      limit_hit = LIMIT_EN & accept & (cnt_inc == MAX_BURST[7:0]);
      if (limit_hit && !other_req) begin
        cnt_d = 8'd0;
      end
      release_grant = (accept & own_last) | ~own_req | (limit_hit & other_req);
      if (release_grant) begin
        prio_d  = ~sel1;
        cnt_d   = 8'd0;
        state_d = other_req ? (sel1 ? GNT0 : GNT1) : IDLE;
      end
    end
  end

  // State, priority, beat count, held address and return tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      addr_q  <= gray_addr;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  // Read data returns one cycle after accept to whichever master owned that beat.
  always_comb begin
    m0_rvalid = rv0_q;
    m1_rvalid = rv1_q;
    m0_rdata  = gray_data;
    m1_rdata  = gray_data;
    busy      = (state_q != IDLE) | rv0_q | rv1_q;
  end

endmodule

// File: tb/tb_gray_read_arbiter.sv
// tb/tb_gray_read_arbiter.sv - directed vector bench for gray_read_arbiter
module tb_gray_read_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_last = 1'b0, m1_req = 1'b0, m1_last = 1'b0;
  logic [13:0] m0_addr = '0, m1_addr = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, gray_req, busy;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [13:0] gray_addr;
  logic        gray_ready = 1'b1;
  logic [7:0]  gray_data = 8'h00;

  int checks = 0;
  int errors = 0;

  gray_read_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_last(m0_last),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_last(m1_last),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .gray_req(gray_req), .gray_addr(gray_addr),
    .gray_ready(gray_ready), .gray_data(gray_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = a[7:0] ^ 8'h5A, one-cycle read latency.
  always @(posedge clk) begin
    if (gray_req && gray_ready) gray_data <= gray_addr[7:0] ^ 8'h5A;
  end

  typedef struct {
    logic        rst, q0, l0, q1, l1, rdy;
    logic [13:0] a0, a1;
    logic [5:0]  ef;   // {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, gray_req, busy}
    logic [13:0] ea;
    logic [7:0]  ed;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic q0, input int a0, input logic l0,
                              input logic q1, input int a1, input logic l1, input logic rdy,
                              input logic [5:0] ef, input int ea, input logic [7:0] ed);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.a0 = 14'(a0); v.l0 = l0;
    v.q1 = q1; v.a1 = 14'(a1); v.l1 = l1; v.rdy = rdy;
    v.ef = ef; v.ea = 14'(ea); v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  vec_t tbl[$];
  int   exp_m[$];
  int   exp_a[$];

  initial begin
    int i0, i1, got;

    // reset, solo m0 burst 0..2
    tbl.push_back(mk(0, 0,  0,0, 0,  0,0, 1, 6'b000000,  0, 8'h00));
    tbl.push_back(mk(1, 0,  0,0, 0,  0,0, 1, 6'b000000,  0, 8'h00));
    tbl.push_back(mk(1, 1,  0,0, 0,  0,0, 1, 6'b000000,  0, 8'h00));
    tbl.push_back(mk(1, 1,  0,0, 0,  0,0, 1, 6'b100011,  0, 8'h00));
    tbl.push_back(mk(1, 1,  1,0, 0,  0,0, 1, 6'b101011,  1, 8'h5A));
    tbl.push_back(mk(1, 1,  2,1, 0,  0,0, 1, 6'b101011,  2, 8'h5B));
    tbl.push_back(mk(1, 0,  0,0, 0,  0,0, 1, 6'b001001,  2, 8'h58));
    tbl.push_back(mk(1, 0,  0,0, 0,  0,0, 1, 6'b000000,  2, 8'h00));
    // reset again, simultaneous 2-beat bursts: m0 first, direct handover to m1
    tbl.push_back(mk(0, 0,  0,0, 0,  0,0, 1, 6'b000000,  0, 8'h00));
    tbl.push_back(mk(1, 0,  0,0, 0,  0,0, 1, 6'b000000,  0, 8'h00));
    tbl.push_back(mk(1, 1, 10,0, 1, 20,0, 1, 6'b000000,  0, 8'h00));
    tbl.push_back(mk(1, 1, 10,0, 1, 20,0, 1, 6'b100011, 10, 8'h00));
    tbl.push_back(mk(1, 1, 11,1, 1, 20,0, 1, 6'b101011, 11, 8'h50));
    tbl.push_back(mk(1, 0,  0,0, 1, 20,0, 1, 6'b011011, 20, 8'h51));
    tbl.push_back(mk(1, 0,  0,0, 1, 21,1, 1, 6'b010111, 21, 8'h4E));
    tbl.push_back(mk(1, 0,  0,0, 0,  0,0, 1, 6'b000101, 21, 8'h4F));
    // single-beat m0 burst leaves prio on m1, so the next tie goes to m1
    tbl.push_back(mk(1, 1, 30,1, 0,  0,0, 1, 6'b000000, 21, 8'h00));
    tbl.push_back(mk(1, 1, 30,1, 0,  0,0, 1, 6'b100011, 30, 8'h00));
    tbl.push_back(mk(1, 1, 40,1, 1, 50,1, 1, 6'b001001, 30, 8'h44));
    tbl.push_back(mk(1, 1, 40,1, 1, 50,1, 1, 6'b010011, 50, 8'h00));
    tbl.push_back(mk(1, 1, 40,1, 0,  0,0, 1, 6'b100111, 40, 8'h68));
    tbl.push_back(mk(1, 0,  0,0, 0,  0,0, 1, 6'b001001, 40, 8'h72));
    // backpressure mid-burst on m1
    tbl.push_back(mk(1, 0,  0,0, 1, 60,0, 1, 6'b000000, 40, 8'h00));
    tbl.push_back(mk(1, 0,  0,0, 1, 60,0, 1, 6'b010011, 60, 8'h00));
    tbl.push_back(mk(1, 0,  0,0, 1, 61,0, 0, 6'b000111, 61, 8'h66));
    tbl.push_back(mk(1, 0,  0,0, 1, 61,0, 0, 6'b000011, 61, 8'h00));
    tbl.push_back(mk(1, 0,  0,0, 1, 61,0, 0, 6'b000011, 61, 8'h00));
    tbl.push_back(mk(1, 0,  0,0, 1, 61,0, 1, 6'b010011, 61, 8'h00));
    tbl.push_back(mk(1, 0,  0,0, 1, 62,1, 1, 6'b010111, 62, 8'h67));
    tbl.push_back(mk(1, 0,  0,0, 0,  0,0, 1, 6'b000101, 62, 8'h64));
    tbl.push_back(mk(1, 0,  0,0, 0,  0,0, 1, 6'b000000, 62, 8'h00));

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      m0_req = tbl[i].q0; m0_addr = tbl[i].a0; m0_last = tbl[i].l0;
      m1_req = tbl[i].q1; m1_addr = tbl[i].a1; m1_last = tbl[i].l1;
      gray_ready = tbl[i].rdy;
      #2;
      chk($sformatf("vec%0d_flags", i),
          {26'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, gray_req, busy}, {26'd0, tbl[i].ef});
      chk($sformatf("vec%0d_addr", i), {18'd0, gray_addr}, {18'd0, tbl[i].ea});
      if (tbl[i].ef[3]) chk($sformatf("vec%0d_m0_rdata", i), {24'd0, m0_rdata}, {24'd0, tbl[i].ed});
      if (tbl[i].ef[2]) chk($sformatf("vec%0d_m1_rdata", i), {24'd0, m1_rdata}, {24'd0, tbl[i].ed});
    end

    // Mid-burst asynchronous reset during GNT1 with a return in flight
    @(negedge clk);
    m0_req = 0; m1_req = 1; m1_addr = 14'd70; m1_last = 0; gray_ready = 1;
    @(negedge clk);
    #2 chk("midrst_pre_gnt", {31'd0, m1_gnt}, 32'd1);
    @(negedge clk);
    m1_addr = 14'd71;
    #2 chk("midrst_pre_rvalid", {31'd0, m1_rvalid}, 32'd1);
    reset = 0;
    #1;
    chk("midrst_outputs", {17'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, gray_req, busy, gray_addr},
        32'd0);
    m1_req = 0;
    @(negedge clk);
    reset = 1;
    #2 chk("midrst_no_rvalid", {30'd0, m1_rvalid, busy}, 32'd0);
    @(negedge clk);
    #2 chk("midrst_idle", {30'd0, m1_rvalid, busy}, 32'd0);

    // 10-beat m0 burst against a 2-beat m1 burst, MAX_BURST=4
`ifdef GRAY_ARB_BURST_LIMIT_EN
    for (int k = 0; k < 4; k++)  begin exp_m.push_back(0); exp_a.push_back(100 + k); end
    for (int k = 0; k < 2; k++)  begin exp_m.push_back(1); exp_a.push_back(200 + k); end
    for (int k = 4; k < 10; k++) begin exp_m.push_back(0); exp_a.push_back(100 + k); end
`else
    for (int k = 0; k < 10; k++) begin exp_m.push_back(0); exp_a.push_back(100 + k); end
    for (int k = 0; k < 2; k++)  begin exp_m.push_back(1); exp_a.push_back(200 + k); end
`endif
    i0 = 0; i1 = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      @(negedge clk);
      m0_req = (i0 < 10); m0_addr = 14'(100 + i0); m0_last = (i0 == 9);
      m1_req = (i1 < 2);  m1_addr = 14'(200 + i1); m1_last = (i1 == 1);
      #2;
      if (m0_gnt || m1_gnt) begin
        chk($sformatf("burst_beat%0d", got), {17'd0, m1_gnt, gray_addr},
            {17'd0, exp_m[got][0], 14'(exp_a[got])});
        got++;
        if (m0_gnt) i0++; else i1++;
      end
    end
    chk("burst_beat_count", got, 12);
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    repeat (3) @(negedge clk);
    #2 chk("burst_end_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
